subs_rob: RTL and testbench
===========================

Name: subs_rob

Overview:
- Reorder buffer of per-polynomial descriptors placed directly upstream of the automorphism (substitution) stage.
- The dispatcher allocates one entry per polynomial entering the iNTT, carrying that polynomial's substitution factor; the iNTT marks entries complete by tag, possibly out of order.
- The block presents the oldest entry to the substitution stage in order: it drives ROB_empty and subs_factor, and frees the entry when the substitution stage signals retire.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- TAG_W, $clog2(DEPTH), tag/index width.
- FACTOR_W, 4, width of the substitution factor (matches subs_factor).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  dispatcher requests a new entry.
- alloc_ready  out  1  entry available (not full).
- alloc_factor  in  FACTOR_W  substitution factor for the new polynomial.
- alloc_tag  out  TAG_W  tag granted to the current allocation (tail index).
- cmpl_valid  in  1  iNTT finished the polynomial with cmpl_tag.
- cmpl_tag  in  TAG_W  tag being completed.
- rob_empty  out  1  to ROB_empty; high when the head is not valid-and-complete.
- subs_factor  out  FACTOR_W  factor of the head entry.
- retire  in  1  one-cycle pulse from the substitution stage when it finishes the head polynomial.
- count  out  TAG_W+1  number of occupied entries.
- err  out  1  sticky protocol-error flag.

Behaviour:
- State held in registers:
  - per-entry {valid, done, factor};
  - head_ptr and tail_ptr, each TAG_W+1 bits including a wrap bit.
- Reset (async assert; release synchronous to clk): all valid/done = 0, factors = 0, pointers = 0, err = 0.
  - Outputs after reset: alloc_ready = 1, rob_empty = 1, subs_factor = 0, count = 0, alloc_tag = 0.
  - Reset asserted mid-operation discards all entries immediately; there is no drain.
- full = (head and tail index bits equal) and (wrap bits differ). empty = (head_ptr == tail_ptr).
- alloc_ready = !full, decoded from registers only. A retire in the same cycle does not free a slot for that cycle's allocation.
- alloc_tag = tail_ptr index, combinational. It is valid while alloc_ready is high.
- Allocation fires when alloc_valid && alloc_ready. On the next edge: entry[tail] = {1, 0, alloc_factor} and tail_ptr increments, wrapping modulo 2*DEPTH.
- Completion fires on cmpl_valid.
  - If entry[cmpl_tag] is valid and not done: set done on the next edge.
  - Otherwise set err and leave the entry unchanged.
- rob_empty = !(entry[head].valid && entry[head].done), combinational from registers.
  - A completion of the head at edge N drops rob_empty in the cycle after edge N (one-cycle latency).
- subs_factor = entry[head].factor; it equals 0 when the head is not valid.
  - It is stable for the whole time the substitution stage processes a polynomial, because the head only moves on retire.
- Retire fires on a retire pulse.
  - If rob_empty is low: clear entry[head].valid and entry[head].done, and increment head_ptr.
  - If rob_empty is high: set err and change nothing.
- Simultaneous events in one cycle are all legal and independent:
  - alloc and retire: count is unchanged.
  - alloc and cmpl: cmpl targeting the tail being allocated in that same cycle is an error, because the entry is not yet valid.
  - cmpl and retire on different entries.
- count = tail_ptr - head_ptr, registered-derived.
- Out-of-order completion: an entry completed behind a pending head stays invisible until every older entry has completed and retired.
- err is cleared only by rst.

Decomposition:
- Shared package:
  - rob_entry_t struct {logic valid; logic done; logic [FACTOR_W-1:0] factor};
  - SUBS_FACTOR_W = 4;
  - ROB_DEPTH default.
- One natural sub-module: rob_ptr (wrap-bit pointer with increment), instantiated for head and tail.
- Entry array and error logic stay in subs_rob.

Test Plan:
- Reset, then allocate factors 3, 5, 1 (tags 0, 1, 2), complete tag 0 → rob_empty falls one cycle after completion; subs_factor = 3; count = 3.
- Complete tags 2 then 1, with the head at tag 1 uncompleted until last → rob_empty stays high until tag 1 completes. Retires then present factors 5, then 1, in order.
- Fill all 4 entries → alloc_ready = 0, count = 4. Retire the head with alloc_valid held → no allocation in the retire cycle; the allocation fires the following cycle with alloc_tag = 0 (wrap).
- Complete an unallocated tag, complete an already-done tag, retire while rob_empty = 1 → err rises and stays high; entry contents and pointers are unchanged.
- Same-cycle alloc + retire at count = 2 → count stays 2; tail and head both advance.
- Assert rst with 3 entries pending, mid-retire → outputs return to reset values immediately (rob_empty = 1, count = 0, alloc_ready = 1); a new allocation after release receives tag 0.

Source files
------------

// File: rtl/subs_rob_pkg.sv
// Shared types and constants for the substitution-stage reorder buffer.
package subs_rob_pkg;

   localparam int unsigned SUBS_FACTOR_W = 4;
   localparam int unsigned ROB_DEPTH     = 4;

   typedef struct packed {
      logic                     valid;
      logic                     done;
      logic [SUBS_FACTOR_W-1:0] factor;
   } rob_entry_t;

endpackage

// File: rtl/subs_rob_ptr.sv
// Wrap-bit pointer: index bits plus one extra MSB so full and empty can be told apart.
module subs_rob_ptr #(
   parameter int unsigned W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   logic [W-1:0] ptr_q;

   // Advance on inc; the natural W-bit rollover gives modulo 2*DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (inc) begin
         ptr_q <= ptr_q + W'(1);
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/subs_rob.sv
// Reorder buffer of per-polynomial substitution descriptors. Entries are allocated in
// order, completed by tag in any order, and presented / retired strictly in order.
module subs_rob
   import subs_rob_pkg::*;
#(
   parameter int unsigned DEPTH    = ROB_DEPTH,
   parameter int unsigned TAG_W    = $clog2(DEPTH),
   parameter int unsigned FACTOR_W = SUBS_FACTOR_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alloc_valid,
   output logic                alloc_ready,
   input  logic [FACTOR_W-1:0] alloc_factor,
   output logic [TAG_W-1:0]    alloc_tag,
   input  logic                cmpl_valid,
   input  logic [TAG_W-1:0]    cmpl_tag,
   output logic                rob_empty,
   output logic [FACTOR_W-1:0] subs_factor,
   input  logic                retire,
   output logic [TAG_W:0]      count,
   output logic                err
);

   rob_entry_t entries_q [DEPTH];
   rob_entry_t entries_d [DEPTH];
   logic       err_q, err_d;

   logic [TAG_W:0]   head_ptr, tail_ptr;
   logic [TAG_W-1:0] head_idx, tail_idx;
   logic             full, head_ready;
   logic             alloc_fire, cmpl_ok, retire_ok;

   subs_rob_ptr #(.W(TAG_W + 1)) u_head (
      .clk (clk),
      .rst (rst),
      .inc (retire_ok),
      .ptr (head_ptr)
   );

   subs_rob_ptr #(.W(TAG_W + 1)) u_tail (
      .clk (clk),
      .rst (rst),
      .inc (alloc_fire),
      .ptr (tail_ptr)
   );

   assign head_idx = head_ptr[TAG_W-1:0];
   assign tail_idx = tail_ptr[TAG_W-1:0];

   // Full/ready come from registers only, so a same-cycle retire never frees a slot early.
   assign full        = (head_idx == tail_idx) && (head_ptr[TAG_W] != tail_ptr[TAG_W]);
   assign alloc_ready = !full;
   assign alloc_tag   = tail_idx;
   assign alloc_fire  = alloc_valid && alloc_ready;

   assign head_ready  = entries_q[head_idx].valid && entries_q[head_idx].done;
   assign rob_empty   = !head_ready;
   assign subs_factor = entries_q[head_idx].valid ? entries_q[head_idx].factor : '0;
   assign retire_ok   = retire && head_ready;

   // A tail being allocated this cycle is not yet valid, so completing it is an error.
   assign cmpl_ok = cmpl_valid && entries_q[cmpl_tag].valid && !entries_q[cmpl_tag].done;

   assign count = tail_ptr - head_ptr;
   assign err   = err_q;

   // Next-state of the entry array and sticky error flag. Retire, completion and
   // allocation never legally target the same entry in one cycle.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         entries_d[i] = entries_q[i];
      end
      err_d = err_q;
      if (retire_ok) begin
         entries_d[head_idx].valid = 1'b0;
         entries_d[head_idx].done  = 1'b0;
      end
      if (cmpl_ok) begin
         entries_d[cmpl_tag].done = 1'b1;
      end
      if (alloc_fire) begin
         entries_d[tail_idx].valid  = 1'b1;
         entries_d[tail_idx].done   = 1'b0;
         entries_d[tail_idx].factor = alloc_factor;
      end
      if ((cmpl_valid && !cmpl_ok) || (retire && !head_ready)) begin
         err_d = 1'b1;
      end
   end

   // Entry array and error register; reset discards everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= entries_d[i];
         end
         err_q <= err_d;
      end
   end

endmodule

// File: tb/tb_subs_rob.sv
// Directed bench for subs_rob with a factor scoreboard popped at each retire.
module tb_subs_rob;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       alloc_valid = 1'b0;
   logic       alloc_ready;
   logic [3:0] alloc_factor = '0;
   logic [1:0] alloc_tag;
   logic       cmpl_valid = 1'b0;
   logic [1:0] cmpl_tag = '0;
   logic       rob_empty;
   logic [3:0] subs_factor;
   logic       retire = 1'b0;
   logic [2:0] count;
   logic       err;

   int checks = 0;
   int errors = 0;
   logic [3:0] sb [$];

   subs_rob dut (
      .clk          (clk),
      .rst          (rst),
      .alloc_valid  (alloc_valid),
      .alloc_ready  (alloc_ready),
      .alloc_factor (alloc_factor),
      .alloc_tag    (alloc_tag),
      .cmpl_valid   (cmpl_valid),
      .cmpl_tag     (cmpl_tag),
      .rob_empty    (rob_empty),
      .subs_factor  (subs_factor),
      .retire       (retire),
      .count        (count),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      alloc_valid = 1'b0;
      cmpl_valid  = 1'b0;
      retire      = 1'b0;
      rst         = 1'b1;
      step();
      step();
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic do_alloc(input logic [3:0] f, input logic [1:0] exp_tag);
      chk("alloc_tag", alloc_tag, exp_tag);
      alloc_valid  = 1'b1;
      alloc_factor = f;
      sb.push_back(f);
      step();
      alloc_valid = 1'b0;
   endtask

   task automatic do_cmpl(input logic [1:0] t);
      cmpl_valid = 1'b1;
      cmpl_tag   = t;
      step();
      cmpl_valid = 1'b0;
   endtask

   task automatic do_retire();
      logic [3:0] exp_f;
      exp_f = (sb.size() > 0) ? sb.pop_front() : 4'hx;
      chk("retire_ready", rob_empty, 1'b0);
      chk("retire_factor", subs_factor, exp_f);
      retire = 1'b1;
      step();
      retire = 1'b0;
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_ready", alloc_ready, 1'b1);
      chk("rst_empty", rob_empty, 1'b1);
      chk("rst_factor", subs_factor, 4'd0);
      chk("rst_count", count, 3'd0);
      chk("rst_tag", alloc_tag, 2'd0);
      chk("rst_err", err, 1'b0);

      // Allocate 3,5,1 and complete the head
      do_alloc(4'd3, 2'd0);
      do_alloc(4'd5, 2'd1);
      do_alloc(4'd1, 2'd2);
      chk("cnt3", count, 3'd3);
      chk("empty_pre_cmpl", rob_empty, 1'b1);
      cmpl_valid = 1'b1;
      cmpl_tag   = 2'd0;
      chk("empty_same_cycle", rob_empty, 1'b1);
      step();
      cmpl_valid = 1'b0;
      chk("empty_after_cmpl", rob_empty, 1'b0);
      chk("head_factor3", subs_factor, 4'd3);
      chk("cnt3b", count, 3'd3);
      do_retire();

      // Out-of-order completion: tag 2 before the head (tag 1)
      do_cmpl(2'd2);
      chk("ooo_hidden", rob_empty, 1'b1);
      chk("ooo_factor", subs_factor, 4'd5);
      do_cmpl(2'd1);
      chk("ooo_visible", rob_empty, 1'b0);
      do_retire();
      do_retire();
      chk("drained_empty", rob_empty, 1'b1);
      chk("drained_count", count, 3'd0);
      chk("drained_factor", subs_factor, 4'd0);
      chk("no_err_yet", err, 1'b0);

      // Fill from tag 0, then retire with alloc_valid held
      do_reset();
      do_alloc(4'd7, 2'd0);
      do_alloc(4'd2, 2'd1);
      do_alloc(4'd9, 2'd2);
      do_alloc(4'd4, 2'd3);
      chk("full_ready", alloc_ready, 1'b0);
      chk("full_count", count, 3'd4);
      do_cmpl(2'd0);
      chk("ret_factor7", subs_factor, sb[0]);
      void'(sb.pop_front());
      alloc_valid  = 1'b1;
      alloc_factor = 4'd6;
      retire       = 1'b1;
      chk("held_not_ready", alloc_ready, 1'b0);
      step();
      retire = 1'b0;
      chk("after_ret_count", count, 3'd3);
      chk("after_ret_ready", alloc_ready, 1'b1);
      chk("wrap_tag", alloc_tag, 2'd0);
      sb.push_back(4'd6);
      step();
      alloc_valid = 1'b0;
      chk("refill_count", count, 3'd4);
      chk("refill_ready", alloc_ready, 1'b0);

      // Drain to count 2, then same-cycle alloc + retire
      do_cmpl(2'd1);
      do_retire();
      do_cmpl(2'd2);
      do_retire();
      do_cmpl(2'd3);
      chk("pre_pair_count", count, 3'd2);
      chk("pre_pair_tag", alloc_tag, 2'd1);
      chk("pre_pair_factor", subs_factor, sb[0]);
      void'(sb.pop_front());
      alloc_valid  = 1'b1;
      alloc_factor = 4'd5;
      retire       = 1'b1;
      sb.push_back(4'd5);
      step();
      alloc_valid = 1'b0;
      retire      = 1'b0;
      chk("pair_count", count, 3'd2);
      chk("pair_tag", alloc_tag, 2'd2);
      chk("pair_factor", subs_factor, 4'd6);
      chk("pair_empty", rob_empty, 1'b1);

      // Reset mid-retire with 3 entries pending
      do_alloc(4'd11, 2'd2);
      do_cmpl(2'd0);
      chk("pre_rst_count", count, 3'd3);
      retire = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_empty", rob_empty, 1'b1);
      chk("midrst_count", count, 3'd0);
      chk("midrst_ready", alloc_ready, 1'b1);
      chk("midrst_factor", subs_factor, 4'd0);
      retire = 1'b0;
      step();
      rst = 1'b0;
      sb.delete();
      do_alloc(4'd12, 2'd0);
      chk("post_rst_count", count, 3'd1);

      // Error: complete an unallocated tag
      do_reset();
      do_cmpl(2'd2);
      chk("e1_err", err, 1'b1);
      chk("e1_count", count, 3'd0);
      chk("e1_empty", rob_empty, 1'b1);
      step();
      chk("e1_sticky", err, 1'b1);

      // Error: complete an already-done tag
      do_reset();
      do_alloc(4'd8, 2'd0);
      do_cmpl(2'd0);
      chk("e2_clean", err, 1'b0);
      do_cmpl(2'd0);
      chk("e2_err", err, 1'b1);
      chk("e2_empty", rob_empty, 1'b0);
      chk("e2_factor", subs_factor, 4'd8);
      chk("e2_count", count, 3'd1);

      // Error: retire while rob_empty is high
      do_reset();
      do_alloc(4'd9, 2'd0);
      retire = 1'b1;
      step();
      retire = 1'b0;
      chk("e3_err", err, 1'b1);
      chk("e3_count", count, 3'd1);
      chk("e3_factor", subs_factor, 4'd9);

      // Error: complete the tail in its own allocation cycle
      do_reset();
      alloc_valid  = 1'b1;
      alloc_factor = 4'd2;
      cmpl_valid   = 1'b1;
      cmpl_tag     = 2'd0;
      step();
      alloc_valid = 1'b0;
      cmpl_valid  = 1'b0;
      chk("e4_err", err, 1'b1);
      chk("e4_count", count, 3'd1);
      chk("e4_empty", rob_empty, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
